// File: rtl/alu_seq_pkg.sv
// Shared op-code constants, FSM state encoding and control-width default
// for the ALU sequencer and its op decoder.
package alu_seq_pkg;

  localparam int SIG_COUNT_DEFAULT = 12;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_SHR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_ROR  = 4'd6;
  localparam logic [3:0] OP_ROL  = 4'd7;
  localparam logic [3:0] OP_AND  = 4'd8;
  localparam logic [3:0] OP_OR   = 4'd9;
  localparam logic [3:0] OP_NEG  = 4'd10;
  localparam logic [3:0] OP_NOT  = 4'd11;
  localparam logic [3:0] OP_LAST = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational op decoder: encoded op -> one-hot ALU control, settle-count
// preload (latency - 1) and illegal-op flag.
module alu_op_decoder
  import alu_seq_pkg::*;
#(
  parameter int SIG_COUNT  = SIG_COUNT_DEFAULT,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8,
  parameter int CNT_W      = 4
) (
  input  logic [3:0]           op,
  output logic [SIG_COUNT-1:0] ctrl,
  output logic [CNT_W-1:0]     lat_m1,
  output logic                 illegal
);

  // Codes 12..15 have no matching bit, so illegal ops decode to all-zero.
  for (genvar gi = 0; gi < SIG_COUNT; gi++) begin : g_onehot
    assign ctrl[gi] = (int'(op) == gi);
  end

  always_comb begin
    lat_m1 = '0;
    case (op)
      OP_MUL:  lat_m1 = CNT_W'(MUL_CYCLES - 1);
      OP_DIV:  lat_m1 = CNT_W'(DIV_CYCLES - 1);
      default: lat_m1 = '0;
    endcase
  end

  assign illegal = op_is_illegal(op);

endmodule

// File: rtl/alu_sequencer.sv
// Request/response sequencer holding ALU control and operands stable for an
// op-dependent settle window. Optional DIVZERO_CHK_EN rejects div by zero.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = SIG_COUNT_DEFAULT,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_op,
  input  logic [BITS-1:0]      req_x,
  input  logic [BITS-1:0]      req_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [BITS-1:0]      alu_hi,
  input  logic [BITS-1:0]      alu_lo,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_hi,
  output logic [BITS-1:0]      rsp_lo,
  output logic                 rsp_err
);

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  state_e               state_q, state_d;
  logic [SIG_COUNT-1:0] ctrl_q, ctrl_d;
  logic [BITS-1:0]      x_q, x_d, y_q, y_d;
  logic [BITS-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic                 err_q, err_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [SIG_COUNT-1:0] dec_ctrl;
  logic [CNT_W-1:0]     dec_lat_m1;
  logic                 dec_illegal;
  logic                 div_by_zero;

  alu_op_decoder #(
    .SIG_COUNT  (SIG_COUNT),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES),
    .CNT_W      (CNT_W)
  ) u_dec (
    .op      (req_op),
    .ctrl    (dec_ctrl),
    .lat_m1  (dec_lat_m1),
    .illegal (dec_illegal)
  );

`ifdef DIVZERO_CHK_EN
  assign div_by_zero = (req_op == OP_DIV) && (req_y == '0);
`else
  assign div_by_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    x_d     = x_q;
    y_d     = y_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          x_d = req_x;
          y_d = req_y;
          // Rejected ops never reach the ALU: respond next cycle with zeros.
          if (dec_illegal || div_by_zero) begin
            cnt_d   = '0;
            hi_d    = '0;
            lo_d    = '0;
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            cnt_d   = dec_lat_m1;
            ctrl_d  = dec_ctrl;
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          hi_d    = alu_hi;
          lo_d    = alu_lo;
          err_d   = 1'b0;
          ctrl_d  = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        ctrl_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign alu_ctrl  = ctrl_q;
  assign alu_x     = x_q;
  assign alu_y     = y_q;
  assign rsp_hi    = hi_q;
  assign rsp_lo    = lo_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU stand-in, a directed vector
// table, randomized transactions against a reference model, and a clr test.
module tb_alu_sequencer;

  localparam int BITS  = 32;
  localparam int SC    = 12;
  localparam int MUL_L = 4;
  localparam int DIV_L = 8;
`ifdef DIVZERO_CHK_EN
  localparam bit DZ = 1'b1;
`else
  localparam bit DZ = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            clr;
  logic            req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [3:0]      req_op;
  logic [BITS-1:0] req_x, req_y, alu_x, alu_y, alu_hi, alu_lo, rsp_hi, rsp_lo;
  logic [SC-1:0]   alu_ctrl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer #(
    .BITS(BITS), .SIG_COUNT(SC), .MUL_CYCLES(MUL_L), .DIV_CYCLES(DIV_L)
  ) dut (
    .clk(clk), .clr(clr),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_x(req_x), .req_y(req_y),
    .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y),
    .alu_hi(alu_hi), .alu_lo(alu_lo),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_err(rsp_err)
  );

  // Arithmetic meaning of each op as a 64-bit {hi, lo} value.
  function automatic logic [63:0] alu_func(input int op, input logic [31:0] x, input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    int     sh = int'(y[4:0]);
    longint q, r;
    logic [31:0] t;
    case (op)
      0:  return 64'(sx + sy);
      1:  return 64'(sx - sy);
      2:  return 64'(sx * sy);
      3:  begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      4:  return {32'h0, x >> sh};
      5:  return {32'h0, x << sh};
      6:  begin t = (x >> sh) | (x << (32 - sh)); return {32'h0, t}; end
      7:  begin t = (x << sh) | (x >> (32 - sh)); return {32'h0, t}; end
      8:  return {32'h0, x & y};
      9:  return {32'h0, x | y};
      10: return 64'(-sx);
      11: return {32'h0, ~x};
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  // ALU stand-in: produces garbage unless exactly one control bit is set.
  function automatic logic [63:0] alu_emul(input logic [SC-1:0] c, input logic [31:0] x, input logic [31:0] y);
    int idx = -1;
    int nset = 0;
    for (int i = 0; i < SC; i++) begin
      if (c[i]) begin
        idx = i;
        nset++;
      end
    end
    if (nset != 1) return 64'hDEAD_BEEF_BAAD_F00D;
    return alu_func(idx, x, y);
  endfunction

  assign {alu_hi, alu_lo} = alu_emul(alu_ctrl, alu_x, alu_y);

  typedef struct {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    int          hold;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;
    int          lat;
    logic [11:0] ctrl;
  } vec_t;

  // Reference model: expected response, latency and control for one request.
  function automatic vec_t ref_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y, input int hold);
    vec_t   v;
    logic [63:0] r;
    logic   rej = (op > 4'd11) || (DZ && op == 4'd3 && y == 0);
    v.op = op; v.x = x; v.y = y; v.hold = hold;
    v.err = rej;
    if (rej) begin
      v.hi = 0; v.lo = 0; v.lat = 1; v.ctrl = 0;
    end else begin
      r = alu_func(int'(op), x, y);
      v.hi = r[63:32];
      v.lo = r[31:0];
      v.ctrl = 12'(1) << op;
      v.lat = (op == 4'd2) ? MUL_L + 1 : (op == 4'd3) ? DIV_L + 1 : 2;
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n = 1;
    int ctrl_cnt = 0;
    int ctrl_bad = 0;
    int rdy_bad = 0;
    int stab_bad = 0;
    logic [31:0] hi, lo;
    logic err;
    @(negedge clk);
    chk({tag, ".ready"}, 192'(req_ready), 192'(1));
    req_valid = 1'b1; req_op = v.op; req_x = v.x; req_y = v.y;
    @(negedge clk);
    req_valid = 1'b0; req_op = 4'($urandom); req_x = $urandom; req_y = $urandom;
    while (!rsp_valid && n < 40) begin
      if (alu_ctrl != 0) begin
        ctrl_cnt++;
        if (alu_ctrl !== v.ctrl) ctrl_bad++;
      end
      if (req_ready) rdy_bad++;
      @(negedge clk);
      n++;
    end
    chk({tag, ".latency"}, 192'(n), 192'(v.lat));
    chk({tag, ".ctrl_cycles"}, 192'(ctrl_cnt), 192'(v.err ? 0 : v.lat - 1));
    chk({tag, ".ctrl_value"}, 192'(ctrl_bad), 192'(0));
    chk({tag, ".ready_low"}, 192'(rdy_bad), 192'(0));
    hi = rsp_hi; lo = rsp_lo; err = rsp_err;
    chk({tag, ".rsp"}, {127'(0), err, hi, lo}, {127'(0), v.err, v.hi, v.lo});
    for (int i = 0; i < v.hold; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      if (!rsp_valid || rsp_hi !== hi || rsp_lo !== lo || rsp_err !== err) stab_bad++;
      if (req_ready || alu_ctrl != 0) stab_bad++;
    end
    if (v.hold > 0) chk({tag, ".hold_stable"}, 192'(stab_bad), 192'(0));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".after_hs"}, {178'(0), rsp_valid, req_ready, alu_ctrl}, {178'(0), 1'b0, 1'b1, 12'h0});
    $display("txn %s op=%0d x=%h y=%h hi=%h lo=%h err=%0b lat=%0d", tag, v.op, v.x, v.y, hi, lo, err, n);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {49'(0), req_ready, rsp_valid, alu_ctrl, alu_x, alu_y, rsp_hi, rsp_lo, rsp_err},
              {49'(0), 1'b1, 1'b0, 12'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0});
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    int   seen;
    clr = 1'b1; req_valid = 1'b0; req_op = 0; req_x = 0; req_y = 0; rsp_ready = 1'b0;

    vecs.push_back('{4'd0,  32'd15,         32'd5,  0, 32'h0,        32'd20,       1'b0, 2, 12'h001});
    vecs.push_back('{4'd2,  32'hFFFF_FFF1,  32'd5,  0, 32'hFFFF_FFFF, 32'hFFFF_FFB5, 1'b0, 5, 12'h004});
    vecs.push_back('{4'd13, 32'd7,          32'd9,  0, 32'h0,        32'h0,        1'b1, 1, 12'h000});
    vecs.push_back('{4'd5,  32'd16,         32'd2,  5, 32'h0,        32'd64,       1'b0, 2, 12'h020});
    if (DZ)
      vecs.push_back('{4'd3, 32'd15, 32'd0, 0, 32'h0,  32'h0,        1'b1, 1, 12'h000});
    else
      vecs.push_back('{4'd3, 32'd15, 32'd0, 0, 32'd15, 32'hFFFF_FFFF, 1'b0, 9, 12'h008});
    vecs.push_back('{4'd1,  32'd3,          32'd5,  1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 2, 12'h002});
    vecs.push_back('{4'd3,  32'd17,         32'd5,  0, 32'd2,        32'd3,        1'b0, 9, 12'h008});
    vecs.push_back('{4'd3,  32'hFFFF_FFEF,  32'd5,  2, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, 9, 12'h008});
    vecs.push_back('{4'd6,  32'h8000_0001,  32'd1,  2, 32'h0,        32'hC000_0000, 1'b0, 2, 12'h040});
    vecs.push_back('{4'd7,  32'h8000_0001,  32'd4,  0, 32'h0,        32'h0000_0018, 1'b0, 2, 12'h080});
    vecs.push_back('{4'd8,  32'h0000_F0F0,  32'h0FF0, 0, 32'h0,      32'h0000_00F0, 1'b0, 2, 12'h100});
    vecs.push_back('{4'd9,  32'h0000_F000,  32'h000F, 0, 32'h0,      32'h0000_F00F, 1'b0, 2, 12'h200});
    vecs.push_back('{4'd10, 32'd7,          32'd123, 0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0, 2, 12'h400});
    vecs.push_back('{4'd11, 32'h1234_5678,  32'd0,  1, 32'h0,        32'hEDCB_A987, 1'b0, 2, 12'h800});
    vecs.push_back('{4'd4,  32'h8000_0000,  32'd31, 0, 32'h0,        32'h0000_0001, 1'b0, 2, 12'h010});
    vecs.push_back('{4'd15, 32'd1,          32'd1,  0, 32'h0,        32'h0,        1'b1, 1, 12'h000});

    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    clr = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i], $sformatf("vec%0d", i));

    // clr in the third EXEC cycle of a div discards it immediately.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd3; req_x = 32'd100; req_y = 32'd7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr.pre_exec", 192'(alu_ctrl), 192'(12'h008));
    clr = 1'b1;
    #1;
    chk_reset_outputs("clr.immediate");
    @(negedge clk);
    clr = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid || alu_ctrl != 0) seen++;
    end
    chk("clr.no_response", 192'(seen), 192'(0));
    run_txn('{4'd0, 32'd3, 32'd5, 0, 32'h0, 32'd8, 1'b0, 2, 12'h001}, "post_clr_add");

    for (int t = 0; t < 200; t++) begin
      logic [31:0] rx, ry;
      rx = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ry = ($urandom_range(0, 3) == 0) ? 32'h0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 40)) : $urandom);
      v = ref_model(4'($urandom_range(0, 15)), rx, ry, $urandom_range(0, 3));
      run_txn(v, $sformatf("rnd%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Sequencing controller in front of the combinational 32-bit ALU in the Phase-1 bus datapath. Accepts one encoded operation with its operands through a valid/ready handshake and drives the ALU's 12-bit one-hot control and operand inputs. It holds them stable for an operation-dependent number of settle cycles, then captures the ALU HI/LO result into registers and presents it on a valid/ready response port. Multiply and divide get multi-cycle windows, so the ALU's long paths are timed as multicycle paths.

## Interface
- BITS, 32, operand/result half width
- SIG_COUNT, 12, width of ALU one-hot control
- MUL_CYCLES, 4, settle cycles for mul (≥1)
- DIV_CYCLES, 8, settle cycles for div (≥1)
- clk  in  1  clock, rising edge
- clr  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept request
- req_op  in  4  encoded op: 0 add, 1 sub, 2 mul, 3 div, 4 shr, 5 shl, 6 ror, 7 rol, 8 and, 9 or, 10 neg, 11 not; 12–15 illegal
- req_x, req_y  in  BITS  operands (signed)
- alu_ctrl  out  SIG_COUNT  one-hot ALU control, bit n = op n
- alu_x, alu_y  out  BITS  registered operands to ALU
- alu_hi, alu_lo  in  BITS  ALU result halves
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_hi, rsp_lo  out  BITS  captured result
- rsp_err  out  1  illegal op (or div-by-zero, see Configuration)

## Operation
- FSM states IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: req_ready=1. On req_valid&req_ready, register op, x, y. Load cnt = latency−1, where latency is MUL_CYCLES for mul, DIV_CYCLES for div, and 1 otherwise. Go to EXEC. Illegal op → RESP directly with err=1, hi=lo=0.
- EXEC: alu_ctrl = one-hot of registered op. alu_x/alu_y held. cnt decrements each cycle. When cnt==0: capture alu_hi/alu_lo into rsp regs, err=0, go to RESP.
- RESP: rsp_valid=1, alu_ctrl=0. Stay until rsp_ready, then go to IDLE. rsp_hi/lo/err remain stable while rsp_valid is high.
- alu_ctrl is all-zero in IDLE and RESP, and never has more than one bit set.
- Unary ops (neg, not) pass req_y through unchanged; the ALU ignores it.
- req_ready=0 in EXEC and RESP. There is no request queueing.

## Timing
- Reset values: req_ready=1, rsp_valid=0, alu_ctrl=0, alu_x=alu_y=0, rsp_hi=rsp_lo=0, rsp_err=0, cnt=0.
- Accept at edge T0. EXEC occupies cycles T0..T0+L−1, with capture on edge T0+L. rsp_valid rises after edge T0+L, so latency is L+1 cycles from the request edge to rsp_valid (add: 2, mul: MUL_CYCLES+1, div: DIV_CYCLES+1). Illegal op: rsp_valid after T0+1.
- A response handshake at edge Tr puts the block in IDLE with req_ready=1 in cycle Tr+1. Minimum issue interval is L+2 cycles.
- clr asserted at any point, including mid-EXEC or with rsp_valid high: all outputs go to reset values immediately, the in-flight op is discarded, and no response is produced.

## Configuration
- DIVZERO_CHK_EN defined: a div with registered y==0 goes IDLE→RESP with rsp_err=1 and rsp_hi=rsp_lo=0. alu_ctrl[3] is never asserted. Latency is 1 cycle.
- Not defined: div by zero executes normally for DIV_CYCLES, rsp_err=0, and the result is whatever the ALU produces.

## Structure
- Package alu_seq_pkg: op-code constants (OP_ADD..OP_NOT), OP_LAST=11, FSM state encodings, SIG_COUNT default.
- Sub-module alu_op_decoder (combinational): op → one-hot ctrl, latency select, illegal flag. The top level holds the FSM, counter and registers.

## Test plan
- add x=15, y=5, rsp_ready=1 → alu_ctrl=0x001 for one cycle; rsp_lo=20, rsp_hi=0, rsp_err=0; rsp_valid 2 cycles after accept.
- mul x=−15, y=5 → alu_ctrl=0x004 for exactly MUL_CYCLES=4 cycles; {rsp_hi,rsp_lo}=0xFFFFFFFF_FFFFFFB5; rsp_valid at cycle 5; req_ready low throughout.
- req_op=13 → no alu_ctrl bit ever set; rsp_err=1, hi=lo=0 after 1 cycle.
- shl x=16, y=2 with rsp_ready held low 5 cycles → rsp_valid and rsp_lo=64 stable all 5 cycles; req_valid during that time is not accepted.
- div x=15, y=0 → with DIVZERO_CHK_EN: err=1 after 1 cycle, alu_ctrl[3] never high. Without it: alu_ctrl=0x008 for 8 cycles, err=0.
- clr pulsed in the 3rd EXEC cycle of a div → all outputs at reset values within the same cycle; no rsp_valid follows; a subsequent add 3+5 returns 8.
